// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control for the hazards that forwarding cannot resolve:
// load-use, busy MDU, data-memory wait (with watchdog) and E-stage redirect.
module hazard_ctrl #(
    parameter int MDU_LAT     = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  D_srcA,
    input  logic [4:0]  D_srcB,
    input  logic        D_mduOp,
    input  logic [4:0]  E_dstM,
    input  logic        E_isLoad,
    input  logic        E_mduStart,
    input  logic        e_redirect,
    input  logic        M_memReq,
    input  logic        m_memReady,
    output logic        F_stall,
    output logic        D_stall,
    output logic        D_bubble,
    output logic        E_bubble,
    output logic        M_stall,
    output logic        W_bubble,
    output logic        mdu_busy,
    output logic        mem_err,
    output logic [31:0] stall_cnt
);
    localparam logic [4:0] RNONE = 5'd0;
    localparam int MW = (MDU_LAT > 2) ? $clog2(MDU_LAT) : 1;
    localparam int WW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} memState_t;

    memState_t     memState;
    logic [MW-1:0] mduCnt;
    logic [WW-1:0] waitCnt;

    logic loadUse;
    logic mduHz;
    logic memWait;
    logic freeze;
    logic fStall;

    assign loadUse = E_isLoad && (E_dstM != RNONE) && ((E_dstM == D_srcA) || (E_dstM == D_srcB));
    assign mduHz   = D_mduOp && ((mduCnt != '0) || E_mduStart);
    assign memWait = M_memReq && !m_memReady && (memState != ERR);
    assign freeze  = memWait || (memState == ERR);

    assign fStall  = freeze || (!e_redirect && (loadUse || mduHz));

    // Controls are forced low while rst is held so the pipeline is quiet immediately.
    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        D_bubble = 1'b0;
        E_bubble = 1'b0;
        M_stall  = 1'b0;
        W_bubble = 1'b0;
        if (!rst) begin
            if (freeze) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                M_stall  = 1'b1;
                W_bubble = 1'b1;
            end else if (e_redirect) begin
                D_bubble = 1'b1;
                E_bubble = 1'b1;
            end else if (loadUse || mduHz) begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                E_bubble = 1'b1;
            end
        end
    end

    assign mdu_busy = (mduCnt != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memState  <= RUN;
            mduCnt    <= '0;
            waitCnt   <= '0;
            mem_err   <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (fStall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end

            // The E register is held during a freeze, so an MDU start there is not yet issued.
            if (!freeze) begin
                if (E_mduStart) begin
                    mduCnt <= MW'(MDU_LAT - 1);
                end else if (mduCnt != '0) begin
                    mduCnt <= mduCnt - 1'b1;
                end
            end

            // waitCnt counts completed consecutive wait cycles.
            case (memState)
                RUN: begin
                    if (memWait) begin
                        if (MEM_TIMEOUT == 1) begin
                            memState <= ERR;
                            mem_err  <= 1'b1;
                        end else begin
                            memState <= MEM_WAIT;
                            waitCnt  <= WW'(1);
                        end
                    end
                end
                MEM_WAIT: begin
                    if (!M_memReq || m_memReady) begin
                        memState <= RUN;
                        waitCnt  <= '0;
                    end else if (waitCnt == WW'(MEM_TIMEOUT - 1)) begin
                        memState <= ERR;
                        mem_err  <= 1'b1;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ERR: begin
                    memState <= ERR;
                end
                default: begin
                    memState <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table, directed corner sequences and random
// stimulus checked against a cycle-level behavioural model.
module tb_hazard_ctrl;
    localparam int LAT  = 4;
    localparam int TOUT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  D_srcA = '0, D_srcB = '0, E_dstM = '0;
    logic        D_mduOp = 1'b0, E_isLoad = 1'b0, E_mduStart = 1'b0;
    logic        e_redirect = 1'b0, M_memReq = 1'b0, m_memReady = 1'b0;
    logic        F_stall, D_stall, D_bubble, E_bubble, M_stall, W_bubble;
    logic        mdu_busy, mem_err;
    logic [31:0] stall_cnt;

    hazard_ctrl #(.MDU_LAT(LAT), .MEM_TIMEOUT(TOUT)) dut (
        .clk(clk), .rst(rst),
        .D_srcA(D_srcA), .D_srcB(D_srcB), .D_mduOp(D_mduOp),
        .E_dstM(E_dstM), .E_isLoad(E_isLoad), .E_mduStart(E_mduStart),
        .e_redirect(e_redirect), .M_memReq(M_memReq), .m_memReady(m_memReady),
        .F_stall(F_stall), .D_stall(D_stall), .D_bubble(D_bubble),
        .E_bubble(E_bubble), .M_stall(M_stall), .W_bubble(W_bubble),
        .mdu_busy(mdu_busy), .mem_err(mem_err), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          mRem   = 0;
    int          mWaits = 0;
    bit          mErr   = 1'b0;
    logic [31:0] mStall = '0;

    // Last sampled DUT values, for directed checks
    logic [5:0]  obsCtrl;
    logic        obsBusy, obsErr;
    logic [31:0] obsStall;

    typedef struct packed {
        logic [4:0] srcA;
        logic [4:0] srcB;
        logic       mduOp;
        logic [4:0] dstM;
        logic       isLoad;
        logic       mduStart;
        logic       redirect;
        logic       memReq;
        logic       memReady;
        logic [5:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_stall, W_bubble}
    } vec_t;

    vec_t vecs [11];

    function automatic logic [5:0] ctrlVec();
        return {F_stall, D_stall, D_bubble, E_bubble, M_stall, W_bubble};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRem = 0; mWaits = 0; mErr = 1'b0; mStall = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        D_srcA = 0; D_srcB = 0; D_mduOp = 0; E_dstM = 0; E_isLoad = 0;
        E_mduStart = 0; e_redirect = 0; M_memReq = 0; m_memReady = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        modelReset();
    endtask

    // One cycle: drive at posedge+1, check at negedge, advance model at the edge.
    task automatic step(input logic [4:0] a, input logic [4:0] b, input logic mo,
                        input logic [4:0] d, input logic il, input logic ms,
                        input logic rd, input logic mr, input logic mrdy, input string tag);
        bit wt, frz, lu, mh, fs;
        logic [5:0] exp;
        D_srcA = a; D_srcB = b; D_mduOp = mo; E_dstM = d; E_isLoad = il;
        E_mduStart = ms; e_redirect = rd; M_memReq = mr; m_memReady = mrdy;
        #4;
        wt  = mr && !mrdy && !mErr;
        frz = wt || mErr;
        lu  = il && (d != 0) && (d == a || d == b);
        mh  = mo && (mRem > 0 || ms);
        if (frz)          exp = 6'b110011;
        else if (rd)      exp = 6'b001100;
        else if (lu || mh) exp = 6'b110100;
        else              exp = 6'b000000;
        fs = exp[5];
        obsCtrl = ctrlVec(); obsBusy = mdu_busy; obsErr = mem_err; obsStall = stall_cnt;
        check({tag, " ctrl"}, 32'(obsCtrl), 32'(exp));
        check({tag, " mdu_busy"}, 32'(obsBusy), 32'(mRem > 0));
        check({tag, " mem_err"}, 32'(obsErr), 32'(mErr));
        check({tag, " stall_cnt"}, obsStall, mStall);
        @(posedge clk);
        if (!frz) mRem = ms ? LAT - 1 : (mRem > 0 ? mRem - 1 : 0);
        if (!mErr) begin
            if (wt) begin
                mWaits++;
                if (mWaits >= TOUT) mErr = 1'b1;
            end else begin
                mWaits = 0;
            end
        end
        if (fs) mStall = mStall + 32'd1;
        #1;
    endtask

    initial begin
        vecs[0]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110100};
        vecs[1]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[2]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[3]  = '{5'd3, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b110100};
        vecs[4]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100};
        vecs[5]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 6'b001100};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000};
        vecs[7]  = '{5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 6'b110011};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[9]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
        vecs[10] = '{5'd6, 5'd7, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

        // Outputs held low during reset even with a hazard present
        E_isLoad = 1'b1; E_dstM = 5'd8; D_srcA = 5'd8;
        #2;
        check("reset ctrl", 32'(ctrlVec()), 32'd0);
        doReset();
        #1;
        check("post-reset ctrl", 32'(ctrlVec()), 32'd0);
        check("post-reset stall_cnt", stall_cnt, 32'd0);
        check("post-reset mem_err", 32'(mem_err), 32'd0);
        #3;
        @(posedge clk); #1;

        for (int i = 0; i < 11; i++) begin
            step(vecs[i].srcA, vecs[i].srcB, vecs[i].mduOp, vecs[i].dstM, vecs[i].isLoad,
                 vecs[i].mduStart, vecs[i].redirect, vecs[i].memReq, vecs[i].memReady,
                 $sformatf("vec%0d", i));
            check($sformatf("vec%0d table", i), 32'(obsCtrl), 32'(vecs[i].exp));
        end

        // Load-use then release
        doReset();
        step(5'd8, 5'd0, 0, 5'd8, 1, 0, 0, 0, 0, "lu");
        check("lu stall", 32'(obsCtrl), 32'(6'b110100));
        step(5'd8, 5'd0, 0, 5'd8, 0, 0, 0, 0, 0, "lu release");
        check("lu release ctrl", 32'(obsCtrl), 32'd0);
        check("lu stall_cnt", obsStall, 32'd1);

        // MDU: start cycle plus LAT-1 busy cycles
        begin
            logic [4:0] expF, expB, gotF, gotB;
            expF = 5'b11110; expB = 5'b01110;
            for (int c = 0; c < 5; c++) begin
                step(0, 0, 1, 0, 0, (c == 0), 0, 0, 0, $sformatf("mdu c%0d", c));
                gotF[4-c] = obsCtrl[5];
                gotB[4-c] = obsBusy;
            end
            check("mdu stall pattern", 32'(gotF), 32'(expF));
            check("mdu busy pattern", 32'(gotB), 32'(expB));
        end

        // Memory wait of three cycles, redirect ignored during it
        for (int c = 0; c < 3; c++) begin
            step(0, 0, 0, 0, 0, 0, (c == 1), 1, 0, $sformatf("mw c%0d", c));
            check($sformatf("mw c%0d freeze", c), 32'(obsCtrl), 32'(6'b110011));
        end
        step(0, 0, 0, 0, 0, 0, 0, 1, 1, "mw ready");
        check("mw ready ctrl", 32'(obsCtrl), 32'd0);
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, "mw back in RUN");
        check("mw redirect after", 32'(obsCtrl), 32'(6'b001100));

        // Random traffic (memory forced ready before the watchdog trips)
        for (int n = 0; n < 400; n++) begin
            logic mr, rdy;
            mr  = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 1) == 0) || (mWaits == TOUT - 1);
            step(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ($urandom_range(0, 2) == 0),
                 5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), mr, rdy, $sformatf("rnd%0d", n));
        end

        // Watchdog timeout, frozen pipeline, then asynchronous reset
        doReset();
        for (int c = 0; c < TOUT; c++) begin
            step(0, 0, 0, 0, 0, 0, 0, 1, 0, $sformatf("to c%0d", c));
            check($sformatf("to c%0d no err yet", c), 32'(obsErr), 32'd0);
        end
        step(5'd8, 0, 0, 5'd8, 1, 0, 0, 1, 1, "err ready");
        check("err flag", 32'(obsErr), 32'd1);
        check("err frozen ready", 32'(obsCtrl), 32'(6'b110011));
        step(0, 0, 0, 0, 0, 0, 1, 0, 0, "err idle");
        check("err frozen idle", 32'(obsCtrl), 32'(6'b110011));
        M_memReq = 1'b1; E_isLoad = 1'b1; E_dstM = 5'd8; D_srcA = 5'd8;
        #2 rst = 1'b1;
        #1;
        check("async rst ctrl", 32'(ctrlVec()), 32'd0);
        check("async rst mem_err", 32'(mem_err), 32'd0);
        check("async rst stall_cnt", stall_cnt, 32'd0);
        check("async rst mdu_busy", 32'(mdu_busy), 32'd0);
        doReset();
        #1;
        check("after err reset ctrl", 32'(ctrlVec()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central pipeline-control unit; the stall/flush side of operand forwarding.
- The forwarding path resolves every RAW hazard it can. This block handles the hazards forwarding cannot resolve:
  - load-use;
  - a busy multi-cycle multiply/divide unit (MDU);
  - data-memory wait;
  - control redirect.
- Emits per-stage stall/bubble controls to the F/D/E/M/W pipeline registers.
- Sequential state: MDU busy counter, memory-wait FSM with watchdog, stall-cycle counter.

Parameters:
MDU_LAT, 32, MDU busy cycles per operation, including the start cycle (>=2)
MEM_TIMEOUT, 255, max consecutive memory-wait cycles before error (>=1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
D_srcA  input  5  D-stage source register A; `RNONE (5'd0) = unused
D_srcB  input  5  D-stage source register B; `RNONE = unused
D_mduOp  input  1  D instruction uses the MDU (start op or read HI/LO)
E_dstM  input  5  E-stage load destination register
E_isLoad  input  1  E-stage instruction is a load
E_mduStart  input  1  E-stage instruction starts an MDU operation
e_redirect  input  1  E-stage taken branch/jump (wrong-path D and E)
M_memReq  input  1  M-stage data-memory access in progress
m_memReady  input  1  data memory completes access this cycle
F_stall  output  1  hold F register
D_stall  output  1  hold D register
D_bubble  output  1  load NOP into D
E_bubble  output  1  load NOP into E
M_stall  output  1  hold M register
W_bubble  output  1  load NOP into W
mdu_busy  output  1  MDU counter nonzero
mem_err  output  1  sticky memory-timeout flag
stall_cnt  output  32  cycles with F_stall=1 since reset

Behaviour:
- Reset (async, immediate):
  - FSM=RUN, MDU counter=0, wait counter=0, mem_err=0, stall_cnt=0.
  - All control outputs 0.
- Hazard terms (combinational from inputs and state):
  - load_use = E_isLoad & E_dstM!=`RNONE & (E_dstM==D_srcA | E_dstM==D_srcB).
  - A D source equal to `RNONE never matches.
  - mdu_hz = D_mduOp & (mdu_cnt!=0 | E_mduStart).
  - mem_wait = M_memReq & ~m_memReady & FSM!=ERR.
- Priority is highest first; exactly one case applies per cycle:
  1. mem_wait or FSM==ERR:
     - F_stall=D_stall=1, M_stall=1, W_bubble=1.
     - The E register is held (gated by M_stall); e_redirect is ignored and re-presents next cycle.
  2. e_redirect: D_bubble=E_bubble=1; F loads the target. Overrides load_use and mdu_hz, because the D instruction is wrong-path.
  3. load_use or mdu_hz: F_stall=D_stall=1, E_bubble=1.
  4. Otherwise: all 0.
- MDU counter:
  - Loads MDU_LAT-1 on E_mduStart when case 1 is not active.
  - Otherwise decrements when nonzero. Saturates at 0.
  - Holds during case 1.
  - mdu_busy = (counter != 0).
- Memory FSM:
  - RUN:
    - mem_wait -> MEM_WAIT, wait counter = 1.
  - MEM_WAIT:
    - m_memReady or ~M_memReq -> RUN, counter cleared.
    - Else counter +1.
    - If counter == MEM_TIMEOUT while still waiting -> ERR, mem_err=1.
  - ERR: terminal until rst; pipeline permanently frozen (case 1).
- stall_cnt:
  - Increments every cycle F_stall=1.
  - Wraps modulo 2^32.
- All outputs except counters/flags are combinational; no added latency.

Test Plan:
1. Load-use:
   - Stimulus: E_isLoad=1, E_dstM=8, D_srcA=8, one cycle.
   - Required: F_stall=D_stall=E_bubble=1; next cycle with E_isLoad=0 all 0; stall_cnt=1.
2. No false hazard on register 0:
   - Stimulus: E_isLoad=1, E_dstM=0, D_srcA=0.
   - Required: all controls 0.
3. Redirect beats load-use:
   - Stimulus: load_use and e_redirect=1 same cycle.
   - Required: D_bubble=E_bubble=1, F_stall=0, D_stall=0.
4. MDU with MDU_LAT=4:
   - Stimulus: E_mduStart pulse, then D_mduOp=1 held.
   - Required: stall asserted the start cycle plus 3 following cycles; mdu_busy high exactly 3 cycles after start; released on the 5th cycle.
5. Memory wait:
   - Stimulus: M_memReq=1, m_memReady=0 for 3 cycles, then m_memReady=1.
   - Required: M_stall=W_bubble=F_stall=1 for 3 cycles; FSM back to RUN; e_redirect raised during the wait is ignored.
6. Timeout and reset:
   - Stimulus: MEM_TIMEOUT=4, memory never ready.
   - Required: mem_err=1 after 4 wait cycles; controls frozen even after m_memReady=1.
   - Then assert rst mid-cycle: mem_err, stall_cnt and all outputs drop to 0 immediately, without waiting for a clock edge.
